fpu_add_sub_seq_ctrl: RTL and testbench
=======================================

Name: fpu_add_sub_seq_ctrl

Overview:
- Multi-cycle sequencer for the FPU add/sub datapath, sitting between the FPU issue logic and the add/sub stage registers.
- Accepts one add/sub operation at a time over a valid/ready handshake.
- Resolves the effective rounding mode: DYN selects fcsr.frm; reserved encodings are rejected.
- Steps the datapath through align, add, normalize and round stages using one-hot stage enables, then holds the result valid until the consumer accepts it.

Parameters:
- NORM_MAX_CYCLES, 8, maximum cycles spent in NORM before a forced exit to ROUND (range 1..15).
- CNT_W, 4, width of the NORM cycle counter; must satisfy 2^CNT_W > NORM_MAX_CYCLES.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- start_i  input  1  operation request (valid).
- ready_o  output  1  controller can accept a request.
- op_sub_i  input  1  1 = subtract, 0 = add; sampled on accept.
- rm_i  input  3  instruction rm field; sampled on accept.
- frm_i  input  3  fcsr.frm; sampled on accept.
- flush_i  input  1  pipeline flush / kill.
- norm_done_i  input  1  normalizer reports leading-one aligned.
- result_ready_i  input  1  consumer accepts the result.
- align_en_o  output  1  align-stage register enable.
- add_en_o  output  1  adder-stage register enable.
- norm_en_o  output  1  normalizer step enable.
- round_en_o  output  1  rounder-stage register enable.
- rm_o  output  3  latched effective rounding mode, driven to the rounder.
- sub_o  output  1  latched operation type.
- valid_o  output  1  result valid.
- illegal_rm_o  output  1  one-cycle pulse: request rejected for a reserved rounding mode.
- norm_timeout_o  output  1  sticky: last operation hit a forced NORM exit.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset: state IDLE; counter 0; rm_o=000; sub_o=0; illegal_rm_o=0; norm_timeout_o=0.
- Reset derived outputs: ready_o=1; all enables, valid_o and busy_o = 0.
- Reset has priority over flush_i, and flush_i has priority over everything else.
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE. Enables and valid_o are Moore outputs decoded from state.
- Decodes: align_en_o=ALIGN, add_en_o=ADD, norm_en_o=NORM, round_en_o=ROUND, valid_o=DONE, ready_o=IDLE.
- Accept occurs when start_i && ready_o (IDLE only). Effective rm = frm_i if rm_i==111, else rm_i.
- Illegal accept: if effective rm is 101, 110 or 111, stay in IDLE, leave rm_o and sub_o unchanged, and assert illegal_rm_o for exactly the next cycle.
- Legal accept: latch rm_o=effective rm and sub_o=op_sub_i, clear norm_timeout_o, and go to ALIGN.
- Transitions: ALIGN -> ADD -> NORM, one cycle each.
- NORM:
  - Counter starts at 0 on entry and increments each NORM cycle.
  - If norm_done_i=1, go to ROUND.
  - Else if counter == NORM_MAX_CYCLES-1, go to ROUND and set norm_timeout_o.
  - Else stay in NORM.
  - norm_done_i is ignored outside NORM.
- ROUND -> DONE after one cycle.
- DONE: hold valid_o, rm_o and sub_o stable. On result_ready_i go to IDLE, so ready_o=1 on the next cycle. No same-cycle re-accept.
- Minimum latency (norm_done_i=1 on the first NORM cycle): accept at cycle 0 gives ALIGN 1, ADD 2, NORM 3, ROUND 4, valid_o at cycle 5.
- Flush in any state: go to IDLE next cycle, deassert all enables and valid_o, reset the counter. rm_o, sub_o and norm_timeout_o are kept.
- A start_i concurrent with flush_i is dropped: no accept and no illegal pulse.
- Reset mid-operation: identical to the reset state above; no valid_o is produced.
- start_i while busy is ignored (ready_o=0); the requester must hold start_i.

Test Plan:
- Reset, then start_i with rm_i=000, op_sub_i=1, norm_done_i=1 -> enables ALIGN/ADD/NORM/ROUND one-hot in cycles 1-4; valid_o=1 at cycle 5 with rm_o=000, sub_o=1; result_ready_i at 7 -> ready_o=1 at 8.
- rm_i=111, frm_i=011 -> rm_o=011. Then rm_i=111, frm_i=111 -> illegal_rm_o pulses one cycle, state stays IDLE, no enables. Then rm_i=101 -> same rejection.
- norm_done_i held 0, NORM_MAX_CYCLES=8 -> norm_en_o high exactly 8 cycles, then ROUND; norm_timeout_o=1 and stays 1 until the next legal accept.
- norm_done_i=1 on the 3rd NORM cycle -> norm_en_o high 3 cycles; valid_o at cycle 7 after accept.
- flush_i during NORM, and separately during DONE -> IDLE next cycle, valid_o drops, ready_o=1. Flush coincident with start_i in IDLE -> no accept, no illegal pulse.
- reset_i asserted during ADD -> next cycle: all enables 0, rm_o=000, ready_o=1; result_ready_i held high in DONE with back-to-back starts -> one idle cycle between operations.

Source files
------------

// File: rtl/fpu_add_sub_seq_ctrl.sv
// Sequencer for the FPU add/sub datapath: accepts one operation, resolves the
// rounding mode, walks align/add/normalize/round and holds the result until taken.
module fpu_add_sub_seq_ctrl #(
  parameter int NORM_MAX_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  output logic       ready_o,
  input  logic       op_sub_i,
  input  logic [2:0] rm_i,
  input  logic [2:0] frm_i,
  input  logic       flush_i,
  input  logic       norm_done_i,
  input  logic       result_ready_i,
  output logic       align_en_o,
  output logic       add_en_o,
  output logic       norm_en_o,
  output logic       round_en_o,
  output logic [2:0] rm_o,
  output logic       sub_o,
  output logic       valid_o,
  output logic       illegal_rm_o,
  output logic       norm_timeout_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NORM_MAX_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] norm_cnt_q;
  logic [2:0]       rm_q;
  logic             sub_q;
  logic             illegal_q;
  logic             timeout_q;

  logic [2:0]       eff_rm;
  logic             rm_reserved;
  logic             accept;
  logic             legal_accept;
  logic             norm_forced;

  // rm_i == 111 is DYN: the fcsr frm field supplies the mode instead.
  assign eff_rm       = (rm_i == 3'b111) ? frm_i : rm_i;
  assign rm_reserved  = (eff_rm == 3'b101) || (eff_rm == 3'b110) || (eff_rm == 3'b111);
  assign accept       = (state_q == IDLE) && start_i;
  assign legal_accept = accept && !rm_reserved;
  assign norm_forced  = (state_q == NORM) && !norm_done_i && (norm_cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (legal_accept) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    if (norm_done_i || norm_forced) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flush wins over any accept or stage advance but preserves the latched
  // operation attributes so the rounder sees stable values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      norm_cnt_q <= '0;
      rm_q       <= 3'b000;
      sub_q      <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (flush_i) begin
      state_q    <= IDLE;
      norm_cnt_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= accept && rm_reserved;
      norm_cnt_q <= ((state_q == NORM) && (state_d == NORM)) ? norm_cnt_q + 1'b1 : '0;
      if (legal_accept) begin
        rm_q      <= eff_rm;
        sub_q     <= op_sub_i;
        timeout_q <= 1'b0;
      end else if (norm_forced) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign ready_o        = (state_q == IDLE);
  assign align_en_o     = (state_q == ALIGN);
  assign add_en_o       = (state_q == ADD);
  assign norm_en_o      = (state_q == NORM);
  assign round_en_o     = (state_q == ROUND);
  assign valid_o        = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
  assign rm_o           = rm_q;
  assign sub_o          = sub_q;
  assign illegal_rm_o   = illegal_q;
  assign norm_timeout_o = timeout_q;

endmodule

// File: tb/tb_fpu_add_sub_seq_ctrl.sv
// Directed self-checking bench for fpu_add_sub_seq_ctrl with hand-computed
// expected values; inputs change and outputs are sampled 1ns after each rising edge.
module tb_fpu_add_sub_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i, start_i, op_sub_i, flush_i, norm_done_i, result_ready_i;
  logic [2:0] rm_i, frm_i;
  logic       ready_o, align_en_o, add_en_o, norm_en_o, round_en_o;
  logic [2:0] rm_o;
  logic       sub_o, valid_o, illegal_rm_o, norm_timeout_o, busy_o;

  int check_count = 0;
  int pass_count  = 0;

  logic [3:0] en;
  assign en = {align_en_o, add_en_o, norm_en_o, round_en_o};

  fpu_add_sub_seq_ctrl #(.NORM_MAX_CYCLES(8), .CNT_W(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .ready_o(ready_o),
    .op_sub_i(op_sub_i), .rm_i(rm_i), .frm_i(frm_i), .flush_i(flush_i),
    .norm_done_i(norm_done_i), .result_ready_i(result_ready_i),
    .align_en_o(align_en_o), .add_en_o(add_en_o), .norm_en_o(norm_en_o),
    .round_en_o(round_en_o), .rm_o(rm_o), .sub_o(sub_o), .valid_o(valid_o),
    .illegal_rm_o(illegal_rm_o), .norm_timeout_o(norm_timeout_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic sub, input logic [2:0] rm,
                               input logic [2:0] frm, input logic ndone, input logic rready,
                               input logic flush);
    start_i = start; op_sub_i = sub; rm_i = rm; frm_i = frm;
    norm_done_i = ndone; result_ready_i = rready; flush_i = flush;
  endtask

  // Bounded wait for valid_o; an expired bound counts as a failed check.
  task automatic waitValid(input int limit);
    int n;
    n = 0;
    while (!valid_o && n < limit) begin
      tick();
      n++;
    end
    if (!valid_o) checkOutput("valid_wait", 32'd0, 32'd1);
  endtask

  task automatic releaseResult();
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask

  initial begin
    int norm_cycles;
    int first_valid;

    reset_i = 1'b1;
    applyStimulus(0, 0, 3'b000, 3'b000, 0, 0, 0);
    tick(); tick();
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_en", en, 4'b0000);
    checkOutput("rst_valid_busy", {valid_o, busy_o}, 2'b00);
    checkOutput("rst_rm_sub", {rm_o, sub_o}, 4'b0000);
    checkOutput("rst_flags", {illegal_rm_o, norm_timeout_o}, 2'b00);
    reset_i = 1'b0;

    // Minimum-latency subtract, result taken at cycle 7
    applyStimulus(1, 1, 3'b000, 3'b000, 1, 0, 0);
    tick(); start_i = 1'b0;
    checkOutput("c1_en", en, 4'b1000);
    checkOutput("c1_busy_ready", {busy_o, ready_o}, 2'b10);
    tick(); checkOutput("c2_en", en, 4'b0100);
    tick(); checkOutput("c3_en", en, 4'b0010);
    tick(); checkOutput("c4_en", en, 4'b0001);
    tick(); checkOutput("c5_valid", valid_o, 1);
    checkOutput("c5_rm_sub", {rm_o, sub_o}, 4'b0001);
    tick(); checkOutput("c6_valid_hold", valid_o, 1);
    tick(); result_ready_i = 1'b1;
    tick(); result_ready_i = 1'b0;
    checkOutput("c8_ready", ready_o, 1);
    checkOutput("c8_valid", valid_o, 0);

    // DYN mode picks frm
    applyStimulus(1, 0, 3'b111, 3'b011, 1, 0, 0);
    tick(); start_i = 1'b0;
    waitValid(10);
    checkOutput("dyn_rm", rm_o, 3'b011);
    checkOutput("dyn_sub", sub_o, 0);
    releaseResult();

    // DYN with reserved frm, then reserved static rm
    applyStimulus(1, 1, 3'b111, 3'b111, 1, 0, 0);
    tick(); start_i = 1'b0;
    checkOutput("ill_dyn_pulse", illegal_rm_o, 1);
    checkOutput("ill_dyn_idle", {busy_o, ready_o, en}, 6'b010000);
    checkOutput("ill_dyn_rm_kept", {rm_o, sub_o}, 4'b0110);
    tick();
    checkOutput("ill_dyn_pulse_end", illegal_rm_o, 0);
    applyStimulus(1, 1, 3'b101, 3'b000, 1, 0, 0);
    tick(); start_i = 1'b0;
    checkOutput("ill_101_pulse", illegal_rm_o, 1);
    checkOutput("ill_101_idle", {busy_o, en}, 5'b00000);
    tick();
    checkOutput("ill_101_pulse_end", illegal_rm_o, 0);

    // NORM timeout after exactly 8 cycles
    applyStimulus(1, 0, 3'b001, 3'b000, 0, 0, 0);
    tick(); start_i = 1'b0;
    norm_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (norm_en_o) norm_cycles++;
      if (round_en_o) break;
    end
    checkOutput("to_norm_cycles", norm_cycles, 8);
    checkOutput("to_in_round", round_en_o, 1);
    checkOutput("to_flag", norm_timeout_o, 1);
    waitValid(5);
    releaseResult();
    tick();
    checkOutput("to_flag_sticky", norm_timeout_o, 1);

    // norm_done on third NORM cycle, valid at cycle 7
    applyStimulus(1, 0, 3'b010, 3'b000, 0, 0, 0);
    tick(); start_i = 1'b0;
    checkOutput("to_flag_cleared", norm_timeout_o, 0);
    norm_cycles = 0;
    first_valid = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      norm_done_i = (cyc == 5);
      if (norm_en_o) norm_cycles++;
      if (valid_o && first_valid == 0) first_valid = cyc;
      if (cyc < 9) tick();
    end
    checkOutput("nd3_norm_cycles", norm_cycles, 3);
    checkOutput("nd3_valid_cycle", first_valid, 7);
    checkOutput("nd3_no_timeout", norm_timeout_o, 0);
    releaseResult();

    // Flush during NORM
    applyStimulus(1, 1, 3'b100, 3'b000, 0, 0, 0);
    tick(); start_i = 1'b0;
    tick(); tick();
    checkOutput("fl_norm_pre", norm_en_o, 1);
    flush_i = 1'b1;
    tick(); flush_i = 1'b0;
    checkOutput("fl_norm_idle", {ready_o, busy_o, valid_o, en}, 7'b1000000);
    checkOutput("fl_norm_rm_kept", {rm_o, sub_o}, 4'b1001);

    // Flush during DONE
    applyStimulus(1, 0, 3'b000, 3'b000, 1, 0, 0);
    tick(); start_i = 1'b0;
    waitValid(10);
    flush_i = 1'b1;
    tick(); flush_i = 1'b0;
    checkOutput("fl_done_idle", {ready_o, valid_o}, 2'b10);

    // Flush with start in IDLE: dropped, even with a reserved mode
    applyStimulus(1, 1, 3'b110, 3'b000, 1, 0, 1);
    tick();
    applyStimulus(0, 0, 3'b000, 3'b000, 0, 0, 0);
    checkOutput("fl_start_drop", {busy_o, illegal_rm_o}, 2'b00);
    applyStimulus(1, 1, 3'b011, 3'b000, 1, 0, 1);
    tick(); applyStimulus(0, 0, 3'b000, 3'b000, 0, 0, 0);
    tick();
    checkOutput("fl_start_drop2", {busy_o, en}, 5'b00000);

    // Reset during ADD
    applyStimulus(1, 1, 3'b011, 3'b000, 1, 0, 0);
    tick(); start_i = 1'b0;
    tick();
    checkOutput("rst_mid_add", add_en_o, 1);
    reset_i = 1'b1;
    tick(); reset_i = 1'b0;
    checkOutput("rst_mid_en", en, 4'b0000);
    checkOutput("rst_mid_rm", {rm_o, sub_o}, 4'b0000);
    checkOutput("rst_mid_ready", {ready_o, valid_o}, 2'b10);

    // Back-to-back with result_ready held high: one idle cycle between ops
    applyStimulus(1, 0, 3'b011, 3'b000, 1, 1, 0);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      tick();
      if (cyc == 5) checkOutput("b2b_valid_c5", valid_o, 1);
      if (cyc == 6) checkOutput("b2b_idle_c6", {ready_o, busy_o}, 2'b10);
      if (cyc == 7) checkOutput("b2b_align_c7", en, 4'b1000);
    end
    applyStimulus(0, 0, 3'b000, 3'b000, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
